// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared widths, op encodings and FSM state codes for the multiply/divide unit
package muldiv_unit_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
   typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
   typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FIX = 2'b10} state_e;
endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_step: one combinational iteration over {acc, q}; is_div picks restoring divide, else shift-add multiply; m is multiplicand/divisor magnitude
module muldiv_step
   import muldiv_unit_pkg::*;
(
   input  logic                  is_div,
   input  logic [DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0] q,
   input  logic [DATA_WIDTH-1:0] m,
   output logic [DATA_WIDTH-1:0] acc_n,
   output logic [DATA_WIDTH-1:0] q_n
);
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] shl;
   logic [DATA_WIDTH-1:0] diff;
   logic                  ge;
   always_comb begin
      sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
      shl   = {acc[DATA_WIDTH-2:0], q[DATA_WIDTH-1]};
      // the shifted remainder is one bit wider than m, so compare on the full width
      ge    = {acc, q[DATA_WIDTH-1]} >= {1'b0, m};
      diff  = shl - m;
      acc_n = is_div ? (ge ? diff : shl) : sum[DATA_WIDTH:1];
      q_n   = is_div ? {q[DATA_WIDTH-2:0], ge} : {sum[0], q[DATA_WIDTH-1:1]};
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers; ports clk, rst, start/op/src_a/src_b request, hi_we/lo_we/wdata MTHI/MTLO, busy/done handshake, hi/lo results
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);
   state_e                  state;
   logic [CNT_WIDTH-1:0]    cnt;
   logic                    is_div, neg_q, neg_r, dz;
   logic [DATA_WIDTH-1:0]   acc, q, m, acc_n, q_n;
   logic                    op_div, op_sgn, a_neg, b_neg;
   logic [DATA_WIDTH-1:0]   a_mag, b_mag, res_hi, res_lo;
   logic [2*DATA_WIDTH-1:0] prod;
   muldiv_step u_step (
      .is_div(is_div),
      .acc   (acc),
      .q     (q),
      .m     (m),
      .acc_n (acc_n),
      .q_n   (q_n)
   );
   always_comb begin
      op_div = op == OP_DIV || op == OP_DIVU;
      op_sgn = op == OP_MULT || op == OP_DIV;
      a_neg  = op_sgn & src_a[DATA_WIDTH-1];
      b_neg  = op_sgn & src_b[DATA_WIDTH-1];
      a_mag  = a_neg ? -src_a : src_a;
      b_mag  = b_neg ? -src_b : src_b;
      prod   = neg_q ? -{acc, q} : {acc, q};
      // with a zero divisor every step passes the dividend through acc, so the
      // sign-corrected remainder equals the original dividend
      res_hi = is_div ? (neg_r ? -acc : acc) : prod[2*DATA_WIDTH-1:DATA_WIDTH];
      res_lo = !is_div ? prod[DATA_WIDTH-1:0] : dz ? '1 : (neg_q ? -q : q);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         acc    <= '0;
         q      <= '0;
         m      <= '0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
         if (state == S_RUN) begin
            acc <= acc_n;
            q   <= q_n;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIX;
         end
         if (state == S_FIX) begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
         end
         // accepting in FIX lets a back-to-back start land on the result edge
         if (start && state != S_RUN) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= src_b == '0;
            acc    <= '0;
            q      <= a_mag;
            m      <= b_mag;
         end
      end
endmodule
